axis_to_fifo_rd_bridge: RTL

- Converts an AXI-Stream slave input into a standard-mode (non-FWFT) FIFO read port: rd_en_i, with data one cycle later.
- Lets legacy consumers written against the Lattice FIFO read interface (readout serializers, SPI/UART drain logic) take data from any AXIS producer.
- Small single-clock circular buffer in between; carries tlast alongside each word.

---
 rtl/axis_to_fifo_rd_bridge.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axis_to_fifo_rd_bridge.sv
// AXI-Stream slave to standard-mode (non-FWFT) FIFO read port bridge.
// A small circular buffer stores {tlast, tdata}; read data appears the cycle after rd_en_i.
module axis_to_fifo_rd_bridge #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 2,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              rd_en_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   level_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   FULL_LEVEL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AE_LEVEL   = (AWIDTH+1)'(AE_THRESH);
  localparam logic [AWIDTH:0]   LEVEL_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE    = AWIDTH'(1);

  logic [DWIDTH:0]   mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              tready_q, tready_d;
  logic              empty_q, empty_d;
  logic              ae_q, ae_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic              rd_valid_q, rd_valid_d;
  logic              underflow_q, underflow_d;

  logic              wr_acc;
  logic              rd_acc;
  logic [DWIDTH:0]   rd_word;

  always_comb begin
    wr_acc      = s_axis_tvalid & tready_q;
    rd_acc      = rd_en_i & ~empty_q;
    rd_word     = mem_q[rd_ptr_q];

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    rd_valid_d  = 1'b0;
    underflow_d = underflow_q | (rd_en_i & empty_q);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = rd_word[DWIDTH-1:0];
      rd_last_d  = rd_word[DWIDTH];
      rd_valid_d = 1'b1;
    end

    if (wr_acc && !rd_acc) begin
      level_d = level_q + LEVEL_ONE;
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LEVEL_ONE;
    end

    // Flags look at the post-update level so tready drops on the edge that fills the buffer.
    tready_d = (level_d != FULL_LEVEL);
    empty_d  = (level_d == '0);
    ae_d     = (level_d <= AE_LEVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tready_q    <= 1'b0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tready_q    <= tready_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: the pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  assign s_axis_tready  = tready_q;
  assign rd_data_o      = rd_data_q;
  assign rd_last_o      = rd_last_q;
  assign rd_valid_o     = rd_valid_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = ae_q;
  assign level_o        = level_q;
  assign underflow_o    = underflow_q;

endmodule
